// File: rtl/simd_rf_wb_arbiter.sv
// simd_rf_wb_arbiter: shares the SIMD regfile write port between the FPU
// writeback pipeline and a 2-entry buffered remote-load response stream.
// FPU has fixed priority; a starvation counter forces a remote grant after
// starve_cycles_p consecutive denials. Regfile write port is fully registered.
// Optional macro SIMD_RF_WB_MERGE_EN: retire an FPU request and the remote
// head in the same cycle when they target the same register with disjoint masks.
module simd_rf_wb_arbiter #(
    parameter int unsigned width_p         = 33,
    parameter int unsigned lanes_p         = 4,
    parameter int unsigned addr_width_lp   = 5,
    parameter int unsigned starve_cycles_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         fpu_v_i,
    input  logic [lanes_p-1:0]           fpu_mask_i,
    input  logic [addr_width_lp-1:0]     fpu_addr_i,
    input  logic [lanes_p*width_p-1:0]   fpu_data_i,
    output logic                         fpu_ready_o,
    input  logic                         rem_v_i,
    input  logic [lanes_p-1:0]           rem_mask_i,
    input  logic [addr_width_lp-1:0]     rem_addr_i,
    input  logic [lanes_p*width_p-1:0]   rem_data_i,
    output logic                         rem_ready_o,
    output logic [lanes_p-1:0]           w_v_o,
    output logic [addr_width_lp-1:0]     w_addr_o,
    output logic [lanes_p*width_p-1:0]   w_data_o,
    output logic                         starve_o
);

    localparam int unsigned data_w_lp   = lanes_p * width_p;
    localparam int unsigned starve_w_lp = 4;
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_cycles_p);

    typedef struct packed {
        logic [lanes_p-1:0]       mask;
        logic [addr_width_lp-1:0] addr;
        logic [data_w_lp-1:0]     data;
    } wb_req_t;

    wb_req_t                  mem_q [2];
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic [1:0]               count_q, count_d;
    logic [starve_w_lp-1:0]   starve_q, starve_d;
    logic [lanes_p-1:0]       w_v_q, w_v_d;
    logic [addr_width_lp-1:0] w_addr_q, w_addr_d;
    logic [data_w_lp-1:0]     w_data_q, w_data_d;

    wb_req_t rem_req_c;
    wb_req_t head_c;
    logic    nempty_c;
    logic    full_c;
    logic    force_c;
    logic    merge_c;
    logic    enq_c;
    logic    fpu_gnt_c;
    logic    rem_gnt_c;

    assign rem_req_c = '{mask: rem_mask_i, addr: rem_addr_i, data: rem_data_i};
    assign head_c    = mem_q[rd_ptr_q];
    assign nempty_c  = (count_q != 2'd0);
    assign full_c    = (count_q == 2'd2);
    assign force_c   = (starve_q == starve_max_lp) & nempty_c;
    assign enq_c     = rem_v_i & rem_ready_o;

`ifdef SIMD_RF_WB_MERGE_EN
    assign merge_c = fpu_v_i & nempty_c & (fpu_addr_i == head_c.addr)
                   & ((fpu_mask_i & head_c.mask) == '0);
`else
    assign merge_c = 1'b0;
`endif

    // Handshakes: ready derived from registered state only (plus merge)
    assign rem_ready_o = reset_n_i & ~full_c;
    assign fpu_ready_o = ~force_c | merge_c;
    assign starve_o    = force_c;

    // Grant selection: merge, forced remote, FPU, then remote
    always_comb begin
        fpu_gnt_c = 1'b0;
        rem_gnt_c = 1'b0;
        if (merge_c) begin
            fpu_gnt_c = 1'b1;
            rem_gnt_c = 1'b1;
        end else if (force_c) begin
            rem_gnt_c = 1'b1;
        end else if (fpu_v_i) begin
            fpu_gnt_c = 1'b1;
        end else if (nempty_c) begin
            rem_gnt_c = 1'b1;
        end
    end

    // Next-state for FIFO pointers/count and the starvation counter
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (rem_gnt_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (enq_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        count_d = count_q + 2'(enq_c) - 2'(rem_gnt_c);
        if (rem_gnt_c || !nempty_c) begin
            starve_d = '0;
        end else if (starve_q != starve_max_lp) begin
            starve_d = starve_q + starve_w_lp'(1);
        end
    end

    // Next value of the regfile write port; addr/data hold when idle
    always_comb begin
        w_v_d    = '0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (merge_c) begin
            w_v_d    = fpu_mask_i | head_c.mask;
            w_addr_d = fpu_addr_i;
            for (int unsigned k = 0; k < lanes_p; k++) begin
                w_data_d[k*width_p +: width_p] = head_c.mask[k] ?
                    head_c.data[k*width_p +: width_p] : fpu_data_i[k*width_p +: width_p];
            end
        end else if (rem_gnt_c) begin
            w_v_d    = head_c.mask;
            w_addr_d = head_c.addr;
            w_data_d = head_c.data;
        end else if (fpu_gnt_c) begin
            w_v_d    = fpu_mask_i;
            w_addr_d = fpu_addr_i;
            w_data_d = fpu_data_i;
        end
    end

    // Control and output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            starve_q <= '0;
            w_v_q    <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            w_v_q    <= w_v_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    // FIFO payload storage; validity is tracked by count_q, so no reset needed
    always_ff @(posedge clk_i) begin
        if (enq_c) begin
            mem_q[wr_ptr_q] <= rem_req_c;
        end
    end

    assign w_v_o    = w_v_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

endmodule

// File: tb/tb_simd_rf_wb_arbiter.sv
// Testbench for simd_rf_wb_arbiter: directed vector table, reset and merge
// sequences, then random traffic against a queue-based reference model.
module tb_simd_rf_wb_arbiter;

    localparam int unsigned W      = 33;
    localparam int unsigned L      = 4;
    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = L * W;
    localparam int unsigned STARVE = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fpu_v, rem_v;
    logic [L-1:0]  fpu_mask, rem_mask;
    logic [AW-1:0] fpu_addr, rem_addr;
    logic [DW-1:0] fpu_data, rem_data;
    logic          fpu_ready, rem_ready, starve;
    logic [L-1:0]  w_v;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    always #5 clk = ~clk;

    simd_rf_wb_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .fpu_v_i(fpu_v), .fpu_mask_i(fpu_mask), .fpu_addr_i(fpu_addr),
        .fpu_data_i(fpu_data), .fpu_ready_o(fpu_ready),
        .rem_v_i(rem_v), .rem_mask_i(rem_mask), .rem_addr_i(rem_addr),
        .rem_data_i(rem_data), .rem_ready_o(rem_ready),
        .w_v_o(w_v), .w_addr_o(w_addr), .w_data_o(w_data), .starve_o(starve)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    typedef struct {
        logic [L-1:0]  m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          mq[$];
    int unsigned   mst;
    logic [L-1:0]  mwv;
    logic [AW-1:0] mwa;
    logic [DW-1:0] mwd;

    typedef struct {
        bit fv; int unsigned fm, fa, fb;
        bit rv; int unsigned rm, ra, rb;
        bit efr, err, est; int unsigned ewv, ewa, ewb;
    } vec_t;

    // Lane k carries b+k; b==0 means all-zero data
    function automatic logic [DW-1:0] mk(input int unsigned b);
        logic [DW-1:0] r;
        r = '0;
        if (b != 0) for (int k = 0; k < L; k++) r[k*W +: W] = W'(b + k);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int k = 0; k < L; k++) r[k*W +: W] = {1'($urandom), 32'($urandom)};
        return r;
    endfunction

    function automatic vec_t rw(input bit fv, input int unsigned fm, fa, fb,
                                input bit rv, input int unsigned rm, ra, rb,
                                input bit efr, err, est, input int unsigned ewv, ewa, ewb);
        vec_t v;
        v.fv = fv; v.fm = fm; v.fa = fa; v.fb = fb;
        v.rv = rv; v.rm = rm; v.ra = ra; v.rb = rb;
        v.efr = efr; v.err = err; v.est = est; v.ewv = ewv; v.ewa = ewa; v.ewb = ewb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst = 0;
        mwv = '0;
        mwa = '0;
        mwd = '0;
    endtask

    task automatic drive_idle();
        fpu_v = 0; fpu_mask = '0; fpu_addr = '0; fpu_data = '0;
        rem_v = 0; rem_mask = '0; rem_addr = '0; rem_data = '0;
    endtask

    task automatic drive(input vec_t v);
        fpu_v = v.fv; fpu_mask = L'(v.fm); fpu_addr = AW'(v.fa); fpu_data = mk(v.fb);
        rem_v = v.rv; rem_mask = L'(v.rm); rem_addr = AW'(v.ra); rem_data = mk(v.rb);
    endtask

    // One clock: check handshakes vs model, clock, check write port, advance model
    task automatic step();
        ent_t h, e;
        bit ne, frc, mrg, rg, fg, enq;
        logic [L-1:0] nwv; logic [AW-1:0] nwa; logic [DW-1:0] nwd;
        ne  = (mq.size() > 0);
        if (ne) h = mq[0];
        frc = ne && (mst == STARVE);
        mrg = 0;
`ifdef SIMD_RF_WB_MERGE_EN
        mrg = fpu_v && ne && (fpu_addr == h.a) && ((fpu_mask & h.m) == '0);
`endif
        chk("fpu_ready", DW'(fpu_ready), DW'(!frc || mrg));
        chk("rem_ready", DW'(rem_ready), DW'(mq.size() < 2));
        chk("starve", DW'(starve), DW'(frc));
        rg = 0; fg = 0;
        if (mrg) begin rg = 1; fg = 1; end
        else if (frc) rg = 1;
        else if (fpu_v) fg = 1;
        else if (ne) rg = 1;
        nwv = '0; nwa = mwa; nwd = mwd;
        if (mrg) begin
            nwv = fpu_mask | h.m; nwa = h.a;
            for (int k = 0; k < L; k++)
                nwd[k*W +: W] = h.m[k] ? h.d[k*W +: W] : fpu_data[k*W +: W];
        end else if (rg) begin
            nwv = h.m; nwa = h.a; nwd = h.d;
        end else if (fg) begin
            nwv = fpu_mask; nwa = fpu_addr; nwd = fpu_data;
        end
        enq = rem_v && (mq.size() < 2);
        e.m = rem_mask; e.a = rem_addr; e.d = rem_data;
        @(posedge clk);
        #1;
        chk("w_v", DW'(w_v), DW'(nwv));
        chk("w_addr", DW'(w_addr), DW'(nwa));
        chk("w_data", w_data, nwd);
        mst = (rg || !ne) ? 0 : ((mst < STARVE) ? mst + 1 : mst);
        if (rg) void'(mq.pop_front());
        if (enq) mq.push_back(e);
        mwv = nwv; mwa = nwa; mwd = nwd;
    endtask

    vec_t vt[20];

    initial begin
        vt[0]  = rw(0,0,0,0,    0,0,0,0,      1,1,0, 0,0,0);
        vt[1]  = rw(1,1,0,2,    0,0,0,0,      1,1,0, 1,0,2);
        vt[2]  = rw(0,0,0,0,    0,0,0,0,      1,1,0, 0,0,2);
        vt[3]  = rw(0,0,0,0,    1,15,30,10,   1,1,0, 0,0,2);
        vt[4]  = rw(0,0,0,0,    1,15,31,11,   1,1,0, 15,30,10);
        vt[5]  = rw(0,0,0,0,    1,15,1,12,    1,1,0, 15,31,11);
        vt[6]  = rw(0,0,0,0,    0,0,0,0,      1,1,0, 15,1,12);
        vt[7]  = rw(0,0,0,0,    0,0,0,0,      1,1,0, 0,1,12);
        vt[8]  = rw(1,2,5,20,   1,5,6,30,     1,1,0, 2,5,20);
        vt[9]  = rw(1,2,7,21,   1,8,8,31,     1,1,0, 2,7,21);
        vt[10] = rw(1,2,9,22,   1,1,10,32,    1,0,0, 2,9,22);
        vt[11] = rw(1,2,11,23,  0,0,0,0,      1,0,0, 2,11,23);
        vt[12] = rw(1,2,12,24,  0,0,0,0,      1,0,0, 2,12,24);
        vt[13] = rw(1,2,13,25,  0,0,0,0,      0,0,1, 5,6,30);
        vt[14] = rw(1,2,14,26,  0,0,0,0,      1,1,0, 2,14,26);
        vt[15] = rw(0,0,0,0,    0,0,0,0,      1,1,0, 8,8,31);
        vt[16] = rw(0,0,0,0,    1,0,20,40,    1,1,0, 0,8,31);
        vt[17] = rw(0,0,0,0,    1,15,21,41,   1,1,0, 0,20,40);
        vt[18] = rw(0,0,0,0,    0,0,0,0,      1,1,0, 15,21,41);
        vt[19] = rw(0,0,0,0,    0,0,0,0,      1,1,0, 0,21,41);

        // Reset state
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_v", DW'(w_v), '0);
        chk("rst_w_addr", DW'(w_addr), '0);
        chk("rst_w_data", w_data, '0);
        chk("rst_rem_ready", DW'(rem_ready), '0);
        chk("rst_starve", DW'(starve), '0);
        reset_n = 1'b1;
        model_reset();

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(vt[i]);
            #1;
            chk($sformatf("vec%0d_fpu_ready", i), DW'(fpu_ready), DW'(vt[i].efr));
            chk($sformatf("vec%0d_rem_ready", i), DW'(rem_ready), DW'(vt[i].err));
            chk($sformatf("vec%0d_starve", i), DW'(starve), DW'(vt[i].est));
            step();
            chk($sformatf("vec%0d_w_v", i), DW'(w_v), DW'(vt[i].ewv));
            chk($sformatf("vec%0d_w_addr", i), DW'(w_addr), DW'(vt[i].ewa));
            chk($sformatf("vec%0d_w_data", i), w_data, mk(vt[i].ewb));
        end

        // Reset pulse with a full FIFO and a pending write
        fpu_v = 1; fpu_mask = 4'b0011; fpu_addr = 5'd2; fpu_data = mk(50);
        rem_v = 1; rem_mask = 4'b0001; rem_addr = 5'd3; rem_data = mk(60);
        #1; step();
        #1; step();
        chk("pre_rst_full", DW'(rem_ready), '0);
        drive_idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_w_v", DW'(w_v), '0);
        chk("async_rst_rem_ready", DW'(rem_ready), '0);
        chk("async_rst_w_data", w_data, '0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        step();
        #1;
        step();

`ifdef SIMD_RF_WB_MERGE_EN
        // Merge: disjoint masks to the same register drain together
        drive_idle();
        rem_v = 1; rem_mask = 4'b1100; rem_addr = 5'd3; rem_data = mk(9);
        #1; step();
        drive_idle();
        fpu_v = 1; fpu_mask = 4'b0011; fpu_addr = 5'd3; fpu_data = mk(7);
        #1;
        chk("merge_fpu_ready", DW'(fpu_ready), DW'(1));
        step();
        chk("merge_w_v", DW'(w_v), DW'(4'b1111));
        chk("merge_lane0", DW'(w_data[0 +: W]), DW'(7));
        chk("merge_lane3", DW'(w_data[3*W +: W]), DW'(12));
        drive_idle();
        #1;
        step();
        chk("merge_drained", DW'(w_v), '0);
        // Overlapping masks: FPU first, remote afterwards
        rem_v = 1; rem_mask = 4'b0100; rem_addr = 5'd3; rem_data = mk(9);
        #1; step();
        drive_idle();
        fpu_v = 1; fpu_mask = 4'b0110; fpu_addr = 5'd3; fpu_data = mk(7);
        #1; step();
        chk("overlap_fpu_first", DW'(w_v), DW'(4'b0110));
        drive_idle();
        #1; step();
        chk("overlap_rem_next", DW'(w_v), DW'(4'b0100));
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            fpu_v    = ($urandom_range(3) != 0);
            fpu_mask = L'($urandom);
            fpu_addr = AW'($urandom_range(3));
            fpu_data = rnd_data();
            rem_v    = ($urandom_range(1) != 0);
            rem_mask = L'($urandom);
            rem_addr = AW'($urandom_range(3));
            rem_data = rnd_data();
            #1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
